// File: rtl/nco_loop_ctrl.sv
// nco_loop_ctrl: three-stage gain/shift/saturate pipeline that steers a DDS control word,
// with a hysteretic lock detector evaluated on every control-word update.
`default_nettype none

module nco_loop_ctrl #(
  parameter int ERR_W       = 32,
  parameter int GAIN_W      = 14,
  parameter int PHASE_W     = 16,
  parameter int FRAC_SHIFT  = 16,
  parameter int LOCK_THRESH = 182,
  parameter int LOCK_CNT    = 8,
  parameter int UNLOCK_CNT  = 4
) (
  input  logic               clk_500,
  input  logic               rst_n,
  input  logic               en,
  input  logic               clear,
  input  logic               err_valid,
  input  logic [ERR_W-1:0]   err,
  input  logic [GAIN_W-1:0]  gain,
  input  logic [PHASE_W-1:0] center_word,
  output logic [PHASE_W-1:0] phase_ctrl,
  output logic [PHASE_W-1:0] phase_ctrl_90,
  output logic               phase_valid,
  output logic               sat,
  output logic               lock,
  output logic [1:0]         lock_state
);

  localparam int PROD_W  = ERR_W + GAIN_W + 1;
  localparam int CNT_MAX = (LOCK_CNT > UNLOCK_CNT) ? LOCK_CNT : UNLOCK_CNT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [PHASE_W-1:0] CORR_MIN = {1'b1, {(PHASE_W-1){1'b0}}};
  localparam logic [PHASE_W-1:0] CORR_MAX = {1'b0, {(PHASE_W-1){1'b1}}};
  localparam logic [PHASE_W-1:0] QUARTER  = {2'b01, {(PHASE_W-2){1'b0}}};
  localparam logic [PHASE_W:0]   THRESH   = (PHASE_W+1)'(LOCK_THRESH);
  localparam logic [CNT_W-1:0]   LCNT     = CNT_W'(LOCK_CNT);
  localparam logic [CNT_W-1:0]   UCNT     = CNT_W'(UNLOCK_CNT);
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    UNLOCK = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2,
    HOLD   = 2'd3
  } state_t;

  logic signed [PROD_W-1:0] prod;
  logic signed [PROD_W-1:0] shifted;
  logic [PROD_W-PHASE_W:0]  upper;
  logic                     ovf;
  logic [PHASE_W-1:0]       corr_next;
  logic [PHASE_W-1:0]       corr;
  logic                     corr_sat;
  logic                     v1;
  logic                     v2;
  logic                     upd;
  logic [PHASE_W-1:0]       phase_q;
  logic [PHASE_W-1:0]       mag;
  logic                     in_lock;
  state_t                   state;
  state_t                   state_nx;
  logic [CNT_W-1:0]         cnt;
  logic [CNT_W-1:0]         cnt_nx;
  logic [CNT_W-1:0]         cnt_inc;

  // The value fits in PHASE_W bits only when every bit above the sign position matches it.
  assign shifted   = prod >>> FRAC_SHIFT;
  assign upper     = shifted[PROD_W-1:PHASE_W-1];
  assign ovf       = !((&upper) || (~|upper));
  assign corr_next = ovf ? (shifted[PROD_W-1] ? CORR_MIN : CORR_MAX) : shifted[PHASE_W-1:0];

  always_ff @(posedge clk_500 or negedge rst_n) begin
    if (!rst_n) begin
      prod     <= '0;
      v1       <= 1'b0;
      corr     <= '0;
      corr_sat <= 1'b0;
      v2       <= 1'b0;
    end else if (clear || !en) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else begin
      v1 <= err_valid;
      v2 <= v1;
      if (err_valid) begin
        prod <= PROD_W'($signed(err)) * PROD_W'($signed({1'b0, gain}));
      end
      if (v1) begin
        corr     <= corr_next;
        corr_sat <= ovf;
      end
    end
  end

  assign upd = en && v2 && !clear;

  always_ff @(posedge clk_500 or negedge rst_n) begin
    if (!rst_n) begin
      phase_q     <= '0;
      phase_valid <= 1'b0;
      sat         <= 1'b0;
    end else if (clear) begin
      phase_q     <= center_word;
      phase_valid <= 1'b0;
      sat         <= 1'b0;
    end else begin
      phase_valid <= upd;
      sat         <= upd && corr_sat;
      if (upd) begin
        phase_q <= phase_q + corr;
      end
    end
  end

  assign phase_ctrl    = phase_q;
  assign phase_ctrl_90 = phase_q + QUARTER;

  // The most negative correction has no positive magnitude and is always out of lock.
  assign mag     = corr[PHASE_W-1] ? -corr : corr;
  assign in_lock = (corr != CORR_MIN) && ({1'b0, mag} <= THRESH);
  assign cnt_inc = cnt + CNT_ONE;

  always_ff @(posedge clk_500 or negedge rst_n) begin
    if (!rst_n) begin
      state <= UNLOCK;
      cnt   <= '0;
      lock  <= 1'b0;
    end else if (clear) begin
      state <= UNLOCK;
      cnt   <= '0;
      lock  <= 1'b0;
    end else if (upd) begin
      state <= state_nx;
      cnt   <= cnt_nx;
      lock  <= (state_nx == LOCKED) || (state_nx == HOLD);
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      UNLOCK: begin
        if (in_lock) begin
          if (LOCK_CNT <= 1) begin
            state_nx = LOCKED;
            cnt_nx   = '0;
          end else begin
            state_nx = ACQ;
            cnt_nx   = CNT_ONE;
          end
        end
      end
      ACQ: begin
        if (!in_lock) begin
          state_nx = UNLOCK;
          cnt_nx   = '0;
        end else if (cnt_inc == LCNT) begin
          state_nx = LOCKED;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt_inc;
        end
      end
      LOCKED: begin
        if (!in_lock) begin
          if (UNLOCK_CNT <= 1) begin
            state_nx = UNLOCK;
            cnt_nx   = '0;
          end else begin
            state_nx = HOLD;
            cnt_nx   = CNT_ONE;
          end
        end
      end
      HOLD: begin
        if (in_lock) begin
          state_nx = LOCKED;
          cnt_nx   = '0;
        end else if (cnt_inc == UCNT) begin
          state_nx = UNLOCK;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt_inc;
        end
      end
      default: begin
        state_nx = UNLOCK;
        cnt_nx   = '0;
      end
    endcase
  end

  assign lock_state = state;

endmodule

`default_nettype wire

// File: doc/nco_loop_ctrl.md
NCO_LOOP_CTRL -- requirements
Module: nco_loop_ctrl

Interface
REQ-001 SHALL have parameter ERR_W, default 32, meaning width of the signed loop-filter error.
REQ-002 SHALL have parameter GAIN_W, default 14, meaning width of the unsigned loop gain.
REQ-003 SHALL have parameter PHASE_W, default 16, meaning width of the DDS phase/frequency control word.
REQ-004 SHALL have parameter FRAC_SHIFT, default 16, meaning arithmetic right shift applied to the product.
REQ-005 SHALL have parameter LOCK_THRESH, default 182, meaning maximum |correction| counted as in-lock.
REQ-006 SHALL have parameter LOCK_CNT, default 8, meaning consecutive in-lock samples needed to declare lock.
REQ-007 SHALL have parameter UNLOCK_CNT, default 4, meaning consecutive out-of-lock samples needed to drop lock.
REQ-008 SHALL have port clk_500, input, 1 bit, meaning loop-update clock.
REQ-009 SHALL have port rst_n, input, 1 bit, meaning reset, asynchronous, active-low; clock clk_500.
REQ-010 SHALL have port en, input, 1 bit, meaning loop enable.
REQ-011 SHALL have port clear, input, 1 bit, meaning synchronous loop restart.
REQ-012 SHALL have port err_valid, input, 1 bit, meaning err is a new sample.
REQ-013 SHALL have port err, input, ERR_W bits, signed, meaning loop-filter output.
REQ-014 SHALL have port gain, input, GAIN_W bits, unsigned, meaning loop gain.
REQ-015 SHALL have port center_word, input, PHASE_W bits, meaning control word loaded on clear.
REQ-016 SHALL have port phase_ctrl, output, PHASE_W bits, meaning 0-degree DDS control word.
REQ-017 SHALL have port phase_ctrl_90, output, PHASE_W bits, meaning 90-degree DDS control word.
REQ-018 SHALL have port phase_valid, output, 1 bit, meaning one-cycle pulse on each control-word update.
REQ-019 SHALL have port sat, output, 1 bit, meaning the correction of the current update was saturated.
REQ-020 SHALL have port lock, output, 1 bit, meaning loop locked.
REQ-021 SHALL have port lock_state, output, 2 bits, meaning lock FSM state.

Function
REQ-022 SHALL form the correction in three registered stages: S1 product = signed err x zero-extended gain, full width ERR_W+GAIN_W+1; S2 arithmetic right shift by FRAC_SHIFT (floor), then saturate to signed PHASE_W range, giving corr; S3 update.
REQ-023 SHALL advance a sample through a stage only while en=1; an err_valid accepted at edge N SHALL give its phase_ctrl update and phase_valid=1 in the cycle following edge N+2 (3-cycle latency).
REQ-024 SHALL in S3 set phase_ctrl <= phase_ctrl + corr, computed modulo 2^PHASE_W (wrap, no clamp).
REQ-025 SHALL keep phase_ctrl_90 = phase_ctrl + 2^(PHASE_W-2), computed modulo 2^PHASE_W.
REQ-026 SHALL assert sat for exactly the phase_valid cycle of a sample whose S2 value was clipped.
REQ-027 SHALL, while en=0, clear all pipeline valid bits, hold phase_ctrl and the lock FSM, and keep phase_valid=0; in-flight samples are discarded.
REQ-028 SHALL, when clear=1, on the next edge load phase_ctrl <= center_word, clear the pipeline valids, and put the FSM in UNLOCK with its counter at 0; clear overrides en and any S3 update in the same cycle.
REQ-029 SHALL evaluate the lock FSM only on an S3 update, with in = (|corr| <= LOCK_THRESH), where |-2^(PHASE_W-1)| is treated as out.
REQ-030 SHALL encode FSM states as UNLOCK=0, ACQ=1, LOCKED=2, HOLD=3.
REQ-031 SHALL, in UNLOCK, go to ACQ with cnt=1 on in, else stay.
REQ-032 SHALL, in ACQ, on in increment cnt and go to LOCKED when cnt reaches LOCK_CNT; on out go to UNLOCK with cnt=0.
REQ-033 SHALL, in LOCKED, go to HOLD with cnt=1 on out, else stay.
REQ-034 SHALL, in HOLD, on out increment cnt and go to UNLOCK when cnt reaches UNLOCK_CNT; on in go to LOCKED.
REQ-035 SHALL drive lock=1 exactly in LOCKED and HOLD, registered and updating in the same cycle as phase_valid.
REQ-036 SHALL treat LOCK_CNT=1 as a direct UNLOCK->LOCKED transition on the first in sample (likewise UNLOCK_CNT=1 for LOCKED->UNLOCK).

Reset
REQ-037 SHALL, on rst_n=0, asynchronously clear phase_ctrl to 0, phase_ctrl_90 to 2^(PHASE_W-2), phase_valid, sat, lock, lock_state, the counter and all pipeline registers.

Verification
REQ-038 SHALL cover: err=65536, gain=1 from phase_ctrl=0 -> phase_ctrl=1 and phase_ctrl_90=16385 three cycles after err_valid; err=-131072, gain=3 -> phase_ctrl decreases by 6.
REQ-039 SHALL cover: err=2^31-1, gain=16383 -> corr=32767 and sat=1 for one cycle; err=-2^31, gain=16383 -> corr=-32768 and sat=1.
REQ-040 SHALL cover: phase_ctrl=65535 plus corr=+1 -> phase_ctrl=0 and phase_ctrl_90=16384.
REQ-041 SHALL cover: 8 samples with corr=100 -> lock rises with the 8th phase_valid; then 3 samples with corr=500 -> lock stays 1 (HOLD); a 4th sample with corr=500 -> lock=0 (UNLOCK).
REQ-042 SHALL cover: clear asserted with a sample in S2, center_word=0x1234 -> phase_ctrl=0x1234, no phase_valid for the flushed sample, lock_state=0.
REQ-043 SHALL cover: rst_n pulsed low mid-stream -> all outputs return to their reset values immediately, without waiting for a clock edge.
